// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: data port wins over instruction fetch; each request becomes 1/2/4 byte-bus accesses.
// Latency from the IDLE cycle that samples the request to the ready pulse: load N+2, store N+1 (+IO stall cycles), fetch 6.
// rdy_in low freezes all state; IO stores stall while io_buffer_full is high; ready is a one-cycle pulse with no backpressure.
module mem_ctrl #(
    parameter logic [31:0] IO_ADDR_HI = 32'h00030000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        d_valid,
    input  logic        d_wr,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_value,
    output logic        d_ready,
    output logic [31:0] d_res,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_inst,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {IDLE, DREAD, DWRITE, IREAD, DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] value_q, value_d;
    logic [31:0] data_q, data_d;
    logic        inst_q, inst_d;

    logic [2:0]  nbytes;
    logic [1:0]  cap_idx;
    logic        io_stall;
    logic [2:0]  rd_off;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] size);
        logic [31:0] r;
        case (size[1:0])
            2'd0:    r = {{24{raw[7] & ~size[2]}}, raw[7:0]};
            2'd1:    r = {{16{raw[15] & ~size[2]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Transfer length of the latched request; encoding 3 behaves as a word.
    always_comb begin
        case (size_q[1:0])
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // Byte landing on mem_din this cycle belongs to the address issued at cnt-1.
    assign cap_idx  = 2'(cnt_q - 3'd1);
    assign io_stall = (base_q >= IO_ADDR_HI) && io_buffer_full;
    // While a capture is pending (frozen, or the capture-only last cycle) keep
    // presenting the previous address so mem_din still carries the owed byte.
    assign rd_off   = ((cnt_q == nbytes) || (!rdy_in && (cnt_q != 3'd0)))
                      ? 3'(cnt_q - 3'd1) : cnt_q;

    // Next-state logic: arbitration, byte sequencing, capture and abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        size_d  = size_q;
        value_d = value_q;
        data_d  = data_q;
        inst_d  = inst_q;
        case (state_q)
            IDLE: begin
                if (d_valid) begin
                    state_d = d_wr ? DWRITE : DREAD;
                    base_d  = d_addr;
                    size_d  = d_size;
                    value_d = d_value;
                    inst_d  = 1'b0;
                    cnt_d   = 3'd0;
                    data_d  = 32'd0;
                end else if (i_valid && !flush) begin
                    state_d = IREAD;
                    base_d  = i_addr;
                    size_d  = 3'b010;
                    value_d = 32'd0;
                    inst_d  = 1'b1;
                    cnt_d   = 3'd0;
                    data_d  = 32'd0;
                end
            end
            DREAD, IREAD: begin
                if ((state_q == IREAD) && flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        data_d[{cap_idx, 3'b000} +: 8] = mem_din;
                    end
                    if (cnt_q == nbytes) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            DWRITE: begin
                if (!io_stall) begin
                    if (cnt_q == 3'(nbytes - 3'd1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                // Requester still shows the old request here, so nothing is sampled.
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State register: synchronous reset, global enable freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            base_q  <= 32'd0;
            size_q  <= 3'd0;
            value_q <= 32'd0;
            data_q  <= 32'd0;
            inst_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            size_q  <= size_d;
            value_q <= value_d;
            data_q  <= data_d;
            inst_q  <= inst_d;
        end
    end

    // Bus and completion outputs decoded from the registered state.
    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        d_ready  = 1'b0;
        d_res    = 32'd0;
        i_ready  = 1'b0;
        i_inst   = 32'd0;
        case (state_q)
            DREAD, IREAD: begin
                mem_a = base_q + {29'd0, rd_off};
            end
            DWRITE: begin
                mem_a    = base_q + {29'd0, cnt_q};
                mem_dout = value_q[{cnt_q[1:0], 3'b000} +: 8];
                // A frozen cycle must not repeat the write into an IO buffer.
                mem_wr   = rdy_in && !io_stall;
            end
            DONE: begin
                if (inst_q) begin
                    i_ready = 1'b1;
                    i_inst  = data_q;
                end else begin
                    d_ready = 1'b1;
                    d_res   = extend(data_q, size_q);
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam logic [31:0] IO_HI = 32'h00030000;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        d_valid, d_wr;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_value;
    logic        d_ready;
    logic [31:0] d_res;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_inst;
    logic        flush;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl #(.IO_ADDR_HI(IO_HI)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .d_valid(d_valid), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_value(d_value),
        .d_ready(d_ready), .d_res(d_res),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_inst(i_inst),
        .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_seen = 0;

    always @(posedge clk_in) cyc <= cyc + 1;
    always @(posedge clk_in) if (mem_wr) wr_seen <= wr_seen + 1;

    // RAM region 0x000-0x3FF plus IO window at 0x30000 folded into one array.
    function automatic int ix(input logic [31:0] a);
        return int'({a[16], a[9:0]});
    endfunction

    logic [7:0] bus_ram [0:2047];
    logic [7:0] ref_mem [0:2047];
    logic       poke_en = 1'b0;
    int         poke_ix = 0;
    logic [7:0] poke_dat = 8'd0;

    always @(posedge clk_in) begin
        mem_din <= bus_ram[ix(mem_a)];
        if (poke_en) bus_ram[poke_ix] <= poke_dat;
        else if (mem_wr) bus_ram[ix(mem_a)] <= mem_dout;
    end

    typedef struct {
        bit          inst;
        logic [31:0] val;
        int          issue;
        int          lat;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nb(input logic [2:0] sz);
        if (sz[1:0] == 2'd0) return 1;
        if (sz[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ext_model(input logic [31:0] raw, input logic [2:0] sz);
        logic [31:0] v;
        case (nb(sz))
            1: begin v = raw % 256;   if (!sz[2] && v >= 128)   v = v + 32'hFFFFFF00; end
            2: begin v = raw % 65536; if (!sz[2] && v >= 32768) v = v + 32'hFFFF0000; end
            default: v = raw;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] read_ref(input logic [31:0] addr, input int n);
        logic [31:0] raw = 32'd0;
        for (int k = 0; k < n; k++) raw = raw + (32'(ref_mem[ix(addr + 32'(k))]) << (8 * k));
        return raw;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (d_ready || i_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", {30'd0, d_ready, i_ready}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("ready_port", {30'd0, d_ready, i_ready}, e.inst ? 32'd1 : 32'd2);
                check("result", e.inst ? i_inst : d_res, e.val);
                check("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    task automatic poke(input int idx, input logic [7:0] v);
        poke_en = 1'b1; poke_ix = idx; poke_dat = v;
        ref_mem[idx] = v;
        @(posedge clk_in); #1;
        poke_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; d_valid = 1'b0; i_valid = 1'b0; flush = 1'b0;
        rdy_in = 1'b1; io_buffer_full = 1'b0;
        repeat (2) @(negedge clk_in);
        sbq.delete();
        rst_in = 1'b0;
    endtask

    // Drive rdy_in / io_buffer_full windows and wait for the wanted ready pulse.
    task automatic wait_ready(input int issue, input bit want_inst, input int pj, input int pl,
                              input int sj, input int sl, input logic [31:0] abase, input int an,
                              output bit ok);
        int off;
        ok = 1'b0;
        for (int k = 0; k < 80 && !ok; k++) begin
            @(negedge clk_in);
            off = cyc - issue;
            rdy_in = !(pl > 0 && off >= pj && off < pj + pl);
            io_buffer_full = (sl > 0 && off >= sj && off < sj + sl);
            if (off >= 1 && off <= an) check("mem_a_seq", mem_a, abase + 32'(off - 1));
            if (want_inst ? i_ready : d_ready) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL timeout: ready not seen within 80 cycles (issue cycle %0d)", issue);
            do_reset();
        end
    endtask

    task automatic do_data(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] val, input int pj, input int pl, input int sj, input int sl);
        int n, lat, w0, an, issue;
        logic [31:0] expv;
        bit ok, io;
        n = nb(sz);
        io = (addr >= IO_HI);
        if (wr) begin
            for (int k = 0; k < n; k++) ref_mem[ix(addr + 32'(k))] = 8'(val >> (8 * k));
            expv = 32'd0;
            lat = n + 1 + pl + ((io && sl > 0) ? sl : 0);
        end else begin
            expv = ext_model(read_ref(addr, n), sz);
            lat = n + 2 + pl;
        end
        an = (pl == 0 && sl == 0) ? n : 0;
        @(negedge clk_in);
        rdy_in = 1'b1; io_buffer_full = 1'b0;
        d_valid = 1'b1; d_wr = wr; d_size = sz; d_addr = addr; d_value = val;
        w0 = wr_seen; issue = cyc;
        sbq.push_back('{inst: 1'b0, val: expv, issue: issue, lat: lat});
        wait_ready(issue, 1'b0, pj, pl, sj, sl, addr, an, ok);
        @(posedge clk_in); #1;
        d_valid = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        check("write_count", 32'(wr_seen - w0), wr ? 32'(n) : 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int pj, input int pl);
        int issue;
        bit ok;
        @(negedge clk_in);
        rdy_in = 1'b1;
        i_valid = 1'b1; i_addr = addr; issue = cyc;
        sbq.push_back('{inst: 1'b1, val: read_ref(addr, 4), issue: issue, lat: 6 + pl});
        wait_ready(issue, 1'b1, pj, pl, 0, 0, addr, (pl == 0) ? 4 : 0, ok);
        @(posedge clk_in); #1;
        i_valid = 1'b0; rdy_in = 1'b1;
    endtask

    // Data and fetch requested together: load first, fetch sampled after its DONE.
    task automatic do_dual(input logic [31:0] daddr, input logic [31:0] iaddr);
        int issue;
        bit ok;
        @(negedge clk_in);
        d_valid = 1'b1; d_wr = 1'b0; d_size = 3'b010; d_addr = daddr;
        i_valid = 1'b1; i_addr = iaddr; issue = cyc;
        sbq.push_back('{inst: 1'b0, val: read_ref(daddr, 4), issue: issue, lat: 6});
        sbq.push_back('{inst: 1'b1, val: read_ref(iaddr, 4), issue: issue, lat: 13});
        wait_ready(issue, 1'b0, 0, 0, 0, 0, daddr, 4, ok);
        @(posedge clk_in); #1;
        d_valid = 1'b0;
        if (ok) begin
            wait_ready(issue, 1'b1, 0, 0, 0, 0, 32'd0, 0, ok);
            @(posedge clk_in); #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] iaddr);
        int nrdy;
        // flush held in IDLE keeps a pending fetch from starting
        @(negedge clk_in);
        i_valid = 1'b1; i_addr = iaddr; flush = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            check("flush_idle_mem_a", mem_a, 32'd0);
        end
        flush = 1'b0; i_valid = 1'b0;
        // flush in the second IREAD cycle aborts with no i_ready
        @(negedge clk_in);
        i_valid = 1'b1; i_addr = iaddr;
        @(negedge clk_in);
        @(negedge clk_in);
        flush = 1'b1; i_valid = 1'b0;
        @(negedge clk_in);
        flush = 1'b0;
        check("flush_abort_mem_a", mem_a, 32'd0);
        nrdy = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (i_ready) nrdy++;
        end
        check("flush_no_ready", 32'(nrdy), 32'd0);
    endtask

    task automatic do_rst_mid(input logic [31:0] addr, input logic [31:0] val);
        int w0;
        @(negedge clk_in);
        d_valid = 1'b1; d_wr = 1'b1; d_size = 3'b010; d_addr = addr; d_value = val;
        w0 = wr_seen;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        ref_mem[ix(addr)]       = val[7:0];
        ref_mem[ix(addr + 32'd1)] = val[15:8];
        @(negedge clk_in);
        check("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mid_mem_a", mem_a, 32'd0);
        check("rst_mid_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_mid_d_ready", {31'd0, d_ready}, 32'd0);
        check("rst_mid_i_ready", {31'd0, i_ready}, 32'd0);
        check("rst_mid_d_res", d_res, 32'd0);
        check("rst_mid_writes", 32'(wr_seen - w0), 32'd2);
        d_valid = 1'b0; rst_in = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; d_valid = 1'b0; d_wr = 1'b0; d_size = 3'd0;
        d_addr = 32'd0; d_value = 32'd0; i_valid = 1'b0; i_addr = 32'd0;
        flush = 1'b0; io_buffer_full = 1'b0;
        for (int i = 0; i < 2048; i++) poke(i, 8'($urandom));
        @(negedge clk_in);
        check("rst_d_ready", {31'd0, d_ready}, 32'd0);
        check("rst_i_ready", {31'd0, i_ready}, 32'd0);
        check("rst_d_res", d_res, 32'd0);
        check("rst_i_inst", i_inst, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst_in = 1'b0;

        poke(ix(32'h100), 8'h78); poke(ix(32'h101), 8'h56);
        poke(ix(32'h102), 8'h34); poke(ix(32'h103), 8'h12);
        do_data(1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 0, 0);
        poke(ix(32'h40), 8'h80);
        do_data(1'b0, 3'b000, 32'h40, 32'd0, 0, 0, 0, 0);
        do_data(1'b0, 3'b100, 32'h40, 32'd0, 0, 0, 0, 0);
        poke(ix(32'h50), 8'h34); poke(ix(32'h51), 8'hF2);
        do_data(1'b0, 3'b001, 32'h50, 32'd0, 0, 0, 0, 0);
        poke(ix(32'h202), 8'h5A);
        do_data(1'b1, 3'b001, 32'h200, 32'h1234ABCD, 0, 0, 0, 0);
        do_data(1'b0, 3'b010, 32'h200, 32'd0, 0, 0, 0, 0);
        do_dual(32'h100, 32'h40);
        do_data(1'b1, 3'b000, 32'h30000, 32'h000000A5, 0, 0, 1, 3);
        do_data(1'b0, 3'b010, 32'h100, 32'd0, 2, 3, 0, 0);
        do_flush(32'h80);
        do_fetch(32'h80, 0, 0);
        do_rst_mid(32'h300, $urandom);

        for (int t = 0; t < 200; t++) begin
            int kind, n, pj, pl, sj, sl;
            logic [2:0] sz;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            sz = 3'($urandom);
            n = nb(sz);
            pj = 0; pl = 0; sj = 0; sl = 0;
            if (kind == 0) begin
                a = 32'($urandom_range(0, 32'h3F8));
                if ($urandom_range(0, 2) == 0) begin pj = $urandom_range(1, n + 1); pl = $urandom_range(1, 3); end
                do_data(1'b0, sz, a, 32'd0, pj, pl, 0, 0);
            end else if (kind == 1) begin
                if ($urandom_range(0, 3) == 0) a = IO_HI + 32'($urandom_range(0, 7));
                else a = 32'($urandom_range(0, 32'h3F8));
                if ($urandom_range(0, 2) == 0) begin pj = $urandom_range(1, n); pl = $urandom_range(1, 3); end
                else if ($urandom_range(0, 1) == 0) begin sj = $urandom_range(1, n); sl = $urandom_range(0, 3); end
                do_data(1'b1, sz, a, $urandom, pj, pl, sj, sl);
            end else begin
                if ($urandom_range(0, 2) == 0) begin pj = $urandom_range(1, 5); pl = $urandom_range(1, 3); end
                do_fetch(32'($urandom_range(0, 255)) << 2, pj, pl);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end

        repeat (3) @(negedge clk_in);
        begin
            int mism = 0;
            for (int i = 0; i < 2048; i++) if (bus_ram[i] !== ref_mem[i]) mism++;
            check("ram_contents", 32'(mism), 32'd0);
        end
        check("queue_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
